// File: rtl/nibble_pkg.sv
// Package: nibble_pkg
// Shared word type and counter-width helper for the nibble deserializer
// and its output FIFO.
//   WORD_W     default word width (matches the downstream 4-bit reduction gate)
//   nibble_t   one word of WORD_W bits
//   cnt_width  counter/pointer width for a modulus, never less than 1 bit
package nibble_pkg;

  localparam int WORD_W = 4;

  typedef logic [WORD_W-1:0] nibble_t;

  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Module: nibble_fifo
// DEPTH-entry synchronous FIFO holding completed words.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_i         write push_data_i at the tail (ignored when full)
//   push_data_i    word to enqueue
//   pop_i          advance the head (ignored when empty)
//   head_o         head entry, all-zero when empty
//   full_o         DEPTH entries held
//   empty_o        no entries held
module nibble_fifo
  import nibble_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = cnt_width(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign full_o  = (occ_q == OCC_FULL);
  assign empty_o = (occ_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is only exposed when an entry is valid so stale data never leaks.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    // Explicit wrap keeps pointers modulo DEPTH for non-power-of-two depths.
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/nibble_deserializer.sv
// Module: nibble_deserializer
// Assembles a serial bit stream into WIDTH-bit words and queues them for the
// downstream reduction gate. The bit counter is the only control state.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bit_in       serial data bit
//   bit_valid    bit_in valid this cycle
//   bit_ready    a bit can be accepted this cycle
//   sync         drop partial word, realign at bit 0
//   word_out     head-of-FIFO word, zero when nothing queued
//   word_valid   word_out holds a queued word
//   word_ready   consumer takes word_out this cycle
//   bit_cnt      bits of the current partial word already accepted
module nibble_deserializer
  import nibble_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter int DEPTH     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic                          bit_ready,
  input  logic                          sync,
  output logic [WIDTH-1:0]              word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_base, shift_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit, accept, push, pop;
  logic             fifo_full, fifo_empty;

  assign last_bit = (cnt_q == LAST_CNT);
  // Stall only the word-completing bit when there is no room; word_ready is
  // deliberately not consulted so bit_ready stays a pure function of state.
  assign bit_ready = !(last_bit && fifo_full);
  assign accept    = bit_valid && bit_ready;
  assign push      = accept && last_bit && !sync;
  assign pop       = word_valid && word_ready;

  // sync restarts from an empty register, so an accepted bit becomes bit 0.
  assign shift_base = sync ? '0 : shift_q;

  generate
    if (WIDTH == 1) begin : g_w1
      assign shift_next = bit_in;
    end else if (MSB_FIRST) begin : g_msb
      assign shift_next = {shift_base[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign shift_next = {bit_in, shift_base[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (sync) begin
      shift_d = '0;
      cnt_d   = '0;
      if (accept) begin
        shift_d = shift_next;
        cnt_d   = (LAST_CNT == '0) ? '0 : CNT_W'(1);
      end
    end else if (accept) begin
      if (last_bit) begin
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = shift_next;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  nibble_fifo #(
    .DEPTH (DEPTH),
    .W     (WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (shift_next),
    .pop_i       (pop),
    .head_o      (word_out),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Testbench: drives one MSB-first and one LSB-first deserializer with the
// same stream and checks both against a queue-based reference model.
module tb_nibble_deserializer;

  localparam int W = 4;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst;
  logic bit_in, bit_valid, sync, word_ready;
  logic bit_ready_m, word_valid_m, bit_ready_l, word_valid_l;
  logic [W-1:0] word_out_m, word_out_l;
  logic [1:0]   bit_cnt_m, bit_cnt_l;

  always #5 clk = ~clk;

  nibble_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .DEPTH(D)) dut_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_m), .sync(sync), .word_out(word_out_m),
    .word_valid(word_valid_m), .word_ready(word_ready), .bit_cnt(bit_cnt_m));

  nibble_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .DEPTH(D)) dut_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_l), .sync(sync), .word_out(word_out_l),
    .word_valid(word_valid_l), .word_ready(word_ready), .bit_cnt(bit_cnt_l));

  int total = 0;
  int bad   = 0;

  // Reference model: bits of the partial word in arrival order, and the
  // queued words as seen by each bit-order variant.
  bit           pb[$];
  logic [W-1:0] fm[$];
  logic [W-1:0] fl[$];
  int           seen_111x = 0;
  bit           watch_111x = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !(pb.size() == W - 1 && fm.size() == D);
  endfunction

  task automatic model_reset();
    pb.delete();
    fm.delete();
    fl.delete();
  endtask

  task automatic model_step(input bit bv, input bit b, input bit sy, input bit wr);
    bit acc;
    logic [W-1:0] wm, wl;
    acc = bv && m_ready();
    if (wr && fm.size() != 0) begin
      void'(fm.pop_front());
      void'(fl.pop_front());
    end
    if (sy) begin
      pb.delete();
      if (acc) pb.push_back(b);
    end else if (acc) begin
      pb.push_back(b);
      if (pb.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = pb[i];
          wl[i]     = pb[i];
        end
        fm.push_back(wm);
        fl.push_back(wl);
        pb.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] em, el;
    em = (fm.size() != 0) ? fm[0] : '0;
    el = (fl.size() != 0) ? fl[0] : '0;
    check({tag, "_rdy_m"}, bit_ready_m, m_ready());
    check({tag, "_rdy_l"}, bit_ready_l, m_ready());
    check({tag, "_vld_m"}, word_valid_m, fm.size() != 0);
    check({tag, "_vld_l"}, word_valid_l, fl.size() != 0);
    check({tag, "_word_m"}, word_out_m, em);
    check({tag, "_word_l"}, word_out_l, el);
    check({tag, "_cnt_m"}, bit_cnt_m, pb.size());
    check({tag, "_cnt_l"}, bit_cnt_l, pb.size());
  endtask

  // One clock: check state at the falling edge, drive, clock, update model.
  task automatic cyc(input bit bv, input bit b, input bit sy, input bit wr, input string tag);
    check_all(tag);
    if (watch_111x && word_valid_m && wr && word_out_m[3:1] == 3'b111) seen_111x++;
    bit_valid  = bv;
    bit_in     = b;
    sync       = sy;
    word_ready = wr;
    @(posedge clk);
    model_step(bv, b, sy, wr);
    @(negedge clk);
  endtask

  // Offer one bit until accepted, bounded.
  task automatic send(input bit b, input bit wr, input string tag);
    bit done = 1'b0;
    int n = 0;
    while (!done && n < 16) begin
      done = m_ready();
      cyc(1'b1, b, 1'b0, wr, tag);
      n++;
    end
    check({tag, "_accept_bound"}, done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] bp_pat;
    logic [3:0]  prev, nw;

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sync = 1'b0; word_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    check("reset_rdy", bit_ready_m, 1'b1);
    check("reset_word", word_out_m, 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    // Basic assembly and bit order.
    send(1'b1, 1'b1, "t1"); send(1'b0, 1'b1, "t1");
    send(1'b1, 1'b1, "t1"); send(1'b1, 1'b1, "t1");
    check("t1_valid", word_valid_m, 1'b1);
    check("t1_word_msb", word_out_m, 4'b1011);
    check("t1_word_lsb", word_out_l, 4'b1101);
    check("t1_gate_and", &word_out_m, 1'b0);
    check("t1_gate_or",  |word_out_m, 1'b1);
    check("t1_gate_xor", ^word_out_m, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "t1_pop");
    check("t1_empty", word_valid_m, 1'b0);

    // Backpressure: two words fill the FIFO, the 12th bit stalls.
    bp_pat = 12'b0000_1111_0101;
    for (int i = 0; i < 11; i++) send(bp_pat[11-i], 1'b0, "bp");
    check("bp_rdy_low", bit_ready_m, 1'b0);
    check("bp_cnt3", bit_cnt_m, 2'd3);
    cyc(1'b1, bp_pat[0], 1'b0, 1'b0, "bp_stall");
    check("bp_still_low", bit_ready_m, 1'b0);
    check("bp_w0", word_out_m, 4'b0000);
    cyc(1'b1, bp_pat[0], 1'b0, 1'b1, "bp_pop0");
    check("bp_w1", word_out_m, 4'b1111);
    check("bp_rdy_back", bit_ready_m, 1'b1);
    cyc(1'b1, bp_pat[0], 1'b0, 1'b1, "bp_pop1");
    check("bp_w2", word_out_m, 4'b0101);
    check("bp_cnt0", bit_cnt_m, 2'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "bp_pop2");
    check("bp_empty", word_valid_m, 1'b0);

    // sync realignment.
    watch_111x = 1'b1;
    send(1'b1, 1'b1, "sy"); send(1'b1, 1'b1, "sy"); send(1'b1, 1'b1, "sy");
    check("sy_cnt3", bit_cnt_m, 2'd3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, "sy_edge");
    check("sy_cnt1", bit_cnt_m, 2'd1);
    check("sy_no_word", word_valid_m, 1'b0);
    send(1'b0, 1'b1, "sy"); send(1'b0, 1'b1, "sy"); send(1'b1, 1'b1, "sy");
    check("sy_word_msb", word_out_m, 4'b0001);
    check("sy_word_lsb", word_out_l, 4'b1000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "sy_pop");
    watch_111x = 1'b0;
    check("sy_no_111x", seen_111x, 0);

    // Simultaneous push and pop with one entry queued, 20 words.
    prev = 4'($urandom);
    for (int i = 3; i >= 0; i--) send(prev[i], 1'b0, "pp_first");
    for (int k = 0; k < 20; k++) begin
      nw = 4'($urandom);
      for (int i = 3; i >= 1; i--) send(nw[i], 1'b0, "pp");
      check("pp_head_before", word_out_m, prev);
      send(nw[0], 1'b1, "pp_last");
      check("pp_occupied", word_valid_m, 1'b1);
      check("pp_head_after", word_out_m, nw);
      check("pp_rdy", bit_ready_m, 1'b1);
      prev = nw;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "pp_drain");

    // Asynchronous reset mid-word with a queued word.
    for (int i = 0; i < 4; i++) send(1'($urandom), 1'b0, "ar_fill");
    send(1'b1, 1'b0, "ar_part"); send(1'b0, 1'b0, "ar_part");
    check("ar_cnt2", bit_cnt_m, 2'd2);
    check("ar_queued", word_valid_m, 1'b1);
    bit_valid = 1'b0; word_ready = 1'b0; sync = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_vld0_m", word_valid_m, 1'b0);
    check("ar_vld0_l", word_valid_l, 1'b0);
    check("ar_cnt0_m", bit_cnt_m, 2'd0);
    check("ar_cnt0_l", bit_cnt_l, 2'd0);
    check("ar_word0", word_out_m, 4'b0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send(1'b1, 1'b0, "ar_new"); send(1'b1, 1'b0, "ar_new");
    send(1'b0, 1'b0, "ar_new"); send(1'b0, 1'b0, "ar_new");
    check("ar_clean_msb", word_out_m, 4'b1100);
    check("ar_clean_lsb", word_out_l, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "ar_pop");

    // Randomized traffic against the model.
    repeat (400) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6, "rnd");
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, "drain");
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
